mouse_position_tracker: RTL
===========================

Name: mouse_position_tracker

Overview:
Parametrised successor to the fixed 160x120 mouse position pre-processor. Consumes raw PS/2 packet registers and SEND_INTERRUPT from the mouse master state machine, and maintains X/Y/Z absolute position with:
- configurable limits;
- saturate or wrap mode;
- sensitivity scaling with sub-step remainder accumulation;
- optional Y inversion;
- button edge pulses and an overflow counter.
Sits between the transceiver core and display/VGA consumers.

Parameters:
POS_WIDTH, 10, width of MOUSE_X/Y/Z outputs (unsigned)
LIMIT_X, 640, X range [0, LIMIT_X-1]
LIMIT_Y, 480, Y range [0, LIMIT_Y-1]
LIMIT_Z, 255, Z range [0, LIMIT_Z-1]
SCALE_SHIFT, 0, 0..3; each applied step = (remainder + delta) >>> SCALE_SHIFT
WRAP_MODE, 0, 0 = saturate at limits, 1 = wrap modulo limit
INVERT_Y, 1, 1 = negate DY so Y increases downward (screen coordinates)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
SEND_INTERRUPT  in  1  one-cycle pulse: new packet valid on raw inputs
MOUSE_STATUS_RAW  in  8  PS/2 status byte
MOUSE_DX_RAW  in  8  X delta magnitude byte
MOUSE_DY_RAW  in  8  Y delta magnitude byte
MOUSE_DZ_RAW  in  8  wheel delta, two's complement
RECENTRE  in  1  synchronous recentre request
MOUSE_X  out  POS_WIDTH  X position
MOUSE_Y  out  POS_WIDTH  Y position
MOUSE_Z  out  POS_WIDTH  Z position
MOUSE_STATUS  out  4  status[3:0] of last applied packet
BTN_PRESS  out  3  one-cycle rising-edge pulses {M,R,L}
BTN_RELEASE  out  3  one-cycle falling-edge pulses {M,R,L}
POS_VALID  out  1  one-cycle pulse when positions updated
OVF_COUNT  out  8  saturating count of packets with X or Y overflow

Behaviour:
- Reset (async, clears immediately):
  - X = LIMIT_X/2, Y = LIMIT_Y/2, Z = LIMIT_Z/2.
  - MOUSE_STATUS, BTN_*, POS_VALID, OVF_COUNT = 0.
  - Remainders = 0; pipeline valid = 0.
  - A packet in flight when reset asserts is lost; it never produces POS_VALID.
- Stage 1 (edge after SEND_INTERRUPT): register 9-bit signed deltas.
  - dx = status[6] ? (status[4] ? -256 : +255) : {status[4], DX_RAW}. dy likewise with bits 7/5.
  - dz = sign-extend(DZ_RAW).
  - If INVERT_Y, dy = -dy (9-bit result, saturate +256 to +255).
- Stage 2 (next edge), per axis:
  - sum = rem + d; step = sum >>> SCALE_SHIFT (floor); rem = sum & (2^SCALE_SHIFT - 1). rem is always non-negative.
  - new = pos + step in POS_WIDTH+2 signed.
  - WRAP_MODE = 0: clamp new to [0, LIMIT-1].
  - WRAP_MODE = 1: if new < 0 add LIMIT; if new >= LIMIT subtract LIMIT.
  - Elaboration check: every LIMIT > 256 >> SCALE_SHIFT when WRAP_MODE = 1, and LIMIT <= 2^POS_WIDTH.
- Latency: SEND_INTERRUPT at cycle n gives new outputs plus POS_VALID, BTN_PRESS/BTN_RELEASE at cycle n+2.
- Back-to-back interrupts (every cycle) are all applied in order; stage 2 reads the just-updated position, so no packet is dropped.
- Buttons: press = new[2:0] & ~prev[2:0]; release = ~new & prev. prev updates with each applied packet.
- OVF_COUNT increments by 1 per packet with status[6] | status[7]; it holds at 255.
- RECENTRE:
  - At the next edge, positions are set to centre and remainders cleared.
  - It has priority over a stage-2 packet in the same cycle: that packet is discarded with no POS_VALID and no button pulses, and prev buttons are unchanged.
  - A packet in stage 1 proceeds normally afterwards.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package mouse_pkg:
  - Status bit indices: BTN_L=0, BTN_R=1, BTN_M=2, X_SIGN=4, Y_SIGN=5, X_OVF=6, Y_OVF=7.
  - Delta width DELTA_W=9; overflow saturation constants.
- One sub-module, mouse_axis_accumulator (params LIMIT, POS_WIDTH, SCALE_SHIFT, WRAP_MODE), instantiated three times.
  - It holds position and remainder and implements stage 2 plus recentre.

Test Plan:
- Reset, defaults -> X=320, Y=240, Z=127, OVF_COUNT=0, all pulses 0.
- status 0x09, DX=0x10, DY=0x05, DZ=0x01 -> at n+2: X=336, Y=235, Z=128, BTN_PRESS=001 for 1 cycle, POS_VALID for 1 cycle. Next packet status 0x08 -> BTN_RELEASE=001.
- Three packets status 0x48 -> X=575, 639, 639 (saturated); OVF_COUNT=3. Three packets status 0x18, DX=0x80 from 320 -> 192, 64, 0.
- WRAP_MODE=1: from X=630, DX=0x14 -> X=10. From X=5, status 0x18, DX=0xF6 -> X=635.
- SCALE_SHIFT=2: four packets DX=0x03 from 320 -> X=320, 321, 322, 323.
- RECENTRE in the same cycle a packet is in stage 2 -> X=320, no POS_VALID. SEND_INTERRUPT on two consecutive cycles, DX=0x01 each -> X=322. Async RESET asserted at n+1 -> no POS_VALID at n+2.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants, packet record and delta-decoding helpers for the mouse position tracker.
package mouse_pkg;

    localparam int BTN_L  = 0;
    localparam int BTN_R  = 1;
    localparam int BTN_M  = 2;
    localparam int X_SIGN = 4;
    localparam int Y_SIGN = 5;
    localparam int X_OVF  = 6;
    localparam int Y_OVF  = 7;

    localparam int DELTA_W = 9;

    localparam logic [DELTA_W-1:0] DELTA_POS_SAT  = 9'h0FF;
    localparam logic [DELTA_W-1:0] DELTA_NEG_SAT  = 9'h100;
    localparam logic [7:0]         OVF_COUNT_MAX  = 8'hFF;

    typedef struct packed {
        logic [3:0]         status;
        logic               ovf;
        logic [DELTA_W-1:0] dx;
        logic [DELTA_W-1:0] dy;
        logic [DELTA_W-1:0] dz;
    } packet_t;

    // An overflowed axis reports the extreme value in the direction of its sign bit.
    function automatic logic [DELTA_W-1:0] decode_delta(input logic ovf, input logic sign,
                                                        input logic [7:0] mag);
        logic [DELTA_W-1:0] d;
        if (ovf) begin
            if (sign) begin
                d = DELTA_NEG_SAT;
            end else begin
                d = DELTA_POS_SAT;
            end
        end else begin
            d = {sign, mag};
        end
        return d;
    endfunction

    function automatic logic [DELTA_W-1:0] negate_sat(input logic [DELTA_W-1:0] d);
        logic [DELTA_W-1:0] n;
        if (d == DELTA_NEG_SAT) begin
            n = DELTA_POS_SAT;
        end else begin
            n = ~d + 9'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/mouse_position_tracker_if.sv
// Packet inputs and position/button outputs of the mouse position tracker.
interface mouse_position_tracker_if #(
    parameter int POS_WIDTH = 10
);
    logic                 SEND_INTERRUPT;
    logic [7:0]           MOUSE_STATUS_RAW;
    logic [7:0]           MOUSE_DX_RAW;
    logic [7:0]           MOUSE_DY_RAW;
    logic [7:0]           MOUSE_DZ_RAW;
    logic                 RECENTRE;
    logic [POS_WIDTH-1:0] MOUSE_X;
    logic [POS_WIDTH-1:0] MOUSE_Y;
    logic [POS_WIDTH-1:0] MOUSE_Z;
    logic [3:0]           MOUSE_STATUS;
    logic [2:0]           BTN_PRESS;
    logic [2:0]           BTN_RELEASE;
    logic                 POS_VALID;
    logic [7:0]           OVF_COUNT;

    modport master (
        output SEND_INTERRUPT, MOUSE_STATUS_RAW, MOUSE_DX_RAW, MOUSE_DY_RAW, MOUSE_DZ_RAW, RECENTRE,
        input  MOUSE_X, MOUSE_Y, MOUSE_Z, MOUSE_STATUS, BTN_PRESS, BTN_RELEASE, POS_VALID, OVF_COUNT
    );

    modport slave (
        input  SEND_INTERRUPT, MOUSE_STATUS_RAW, MOUSE_DX_RAW, MOUSE_DY_RAW, MOUSE_DZ_RAW, RECENTRE,
        output MOUSE_X, MOUSE_Y, MOUSE_Z, MOUSE_STATUS, BTN_PRESS, BTN_RELEASE, POS_VALID, OVF_COUNT
    );
endinterface

// File: rtl/mouse_axis_accumulator.sv
// One axis: scaled step with non-negative sub-step remainder, then clamp or wrap into [0, LIMIT-1].
module mouse_axis_accumulator
    import mouse_pkg::*;
#(
    parameter int LIMIT       = 640,
    parameter int POS_WIDTH   = 10,
    parameter int SCALE_SHIFT = 0,
    parameter int WRAP_MODE   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 recentre,
    input  logic                 apply,
    input  logic [DELTA_W-1:0]   delta,
    output logic [POS_WIDTH-1:0] pos
);
    localparam int SUM_W = DELTA_W + 1;
    localparam int CW    = (POS_WIDTH + 2 > SUM_W + 1) ? POS_WIDTH + 2 : SUM_W + 1;

    localparam logic [POS_WIDTH-1:0]  CENTRE   = POS_WIDTH'(LIMIT / 2);
    localparam logic [POS_WIDTH-1:0]  TOP      = POS_WIDTH'(LIMIT - 1);
    localparam logic signed [CW-1:0]  LIM      = CW'(LIMIT);
    localparam logic [SUM_W-1:0]      REM_MASK = SUM_W'((1 << SCALE_SHIFT) - 1);

    logic [POS_WIDTH-1:0]    pos_r;
    logic [3:0]              rem_r;
    logic signed [SUM_W-1:0] sum_s;
    logic signed [SUM_W-1:0] step_s;
    logic signed [CW-1:0]    new_s;
    logic [POS_WIDTH-1:0]    next_pos_s;
    logic [3:0]              next_rem_s;

    // Arithmetic shift floors toward minus infinity, so the masked remainder stays non-negative.
    always_comb begin
        sum_s      = $signed({{(SUM_W-4){1'b0}}, rem_r}) + $signed({delta[DELTA_W-1], delta});
        step_s     = sum_s >>> SCALE_SHIFT;
        next_rem_s = 4'(sum_s & REM_MASK);
        new_s      = $signed({{(CW-POS_WIDTH){1'b0}}, pos_r})
                   + $signed({{(CW-SUM_W){step_s[SUM_W-1]}}, step_s});
        if (WRAP_MODE != 0) begin
            if (new_s[CW-1]) begin
                next_pos_s = POS_WIDTH'(new_s + LIM);
            end else if (new_s >= LIM) begin
                next_pos_s = POS_WIDTH'(new_s - LIM);
            end else begin
                next_pos_s = new_s[POS_WIDTH-1:0];
            end
        end else begin
            if (new_s[CW-1]) begin
                next_pos_s = '0;
            end else if (new_s >= LIM) begin
                next_pos_s = TOP;
            end else begin
                next_pos_s = new_s[POS_WIDTH-1:0];
            end
        end
    end

    // Recentre wins over a packet arriving in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_r <= CENTRE;
            rem_r <= 4'd0;
        end else if (recentre) begin
            pos_r <= CENTRE;
            rem_r <= 4'd0;
        end else if (apply) begin
            pos_r <= next_pos_s;
            rem_r <= next_rem_s;
        end
    end

    assign pos = pos_r;

endmodule

// File: rtl/mouse_position_tracker.sv
// Two-stage PS/2 packet processor: decode deltas, then update X/Y/Z, buttons and overflow count.
module mouse_position_tracker
    import mouse_pkg::*;
#(
    parameter int POS_WIDTH   = 10,
    parameter int LIMIT_X     = 640,
    parameter int LIMIT_Y     = 480,
    parameter int LIMIT_Z     = 255,
    parameter int SCALE_SHIFT = 0,
    parameter int WRAP_MODE   = 0,
    parameter int INVERT_Y    = 1
) (
    input  logic CLK,
    input  logic RESET,
    mouse_position_tracker_if.slave bus
);
    if (SCALE_SHIFT < 0 || SCALE_SHIFT > 3) begin : g_bad_shift
        $error("mouse_position_tracker: SCALE_SHIFT must be 0..3");
    end
    if (LIMIT_X > (1 << POS_WIDTH) || LIMIT_Y > (1 << POS_WIDTH) || LIMIT_Z > (1 << POS_WIDTH)) begin : g_bad_width
        $error("mouse_position_tracker: a LIMIT does not fit in POS_WIDTH");
    end
    if (WRAP_MODE != 0 && (LIMIT_X <= (256 >> SCALE_SHIFT) || LIMIT_Y <= (256 >> SCALE_SHIFT)
                           || LIMIT_Z <= (256 >> SCALE_SHIFT))) begin : g_bad_wrap
        $error("mouse_position_tracker: wrap mode needs every LIMIT above the largest step");
    end

    packet_t              s1_pkt_s;
    packet_t              s1_pkt_r;
    logic                 s1_valid_r;
    logic [DELTA_W-1:0]   dy_raw_s;
    logic                 apply_s;
    logic [3:0]           status_r;
    logic [2:0]           btn_press_r;
    logic [2:0]           btn_release_r;
    logic                 pos_valid_r;
    logic [7:0]           ovf_count_r;
    logic [POS_WIDTH-1:0] x_pos_s;
    logic [POS_WIDTH-1:0] y_pos_s;
    logic [POS_WIDTH-1:0] z_pos_s;

    // Y is negated after decoding so the screen origin sits top-left.
    always_comb begin
        s1_pkt_s.status = bus.MOUSE_STATUS_RAW[3:0];
        s1_pkt_s.ovf    = bus.MOUSE_STATUS_RAW[X_OVF] | bus.MOUSE_STATUS_RAW[Y_OVF];
        s1_pkt_s.dx     = decode_delta(bus.MOUSE_STATUS_RAW[X_OVF], bus.MOUSE_STATUS_RAW[X_SIGN],
                                       bus.MOUSE_DX_RAW);
        dy_raw_s        = decode_delta(bus.MOUSE_STATUS_RAW[Y_OVF], bus.MOUSE_STATUS_RAW[Y_SIGN],
                                       bus.MOUSE_DY_RAW);
        if (INVERT_Y != 0) begin
            s1_pkt_s.dy = negate_sat(dy_raw_s);
        end else begin
            s1_pkt_s.dy = dy_raw_s;
        end
        s1_pkt_s.dz     = {bus.MOUSE_DZ_RAW[7], bus.MOUSE_DZ_RAW};
    end

    // Stage 1: capture the decoded packet on SEND_INTERRUPT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_valid_r <= 1'b0;
            s1_pkt_r   <= '0;
        end else begin
            s1_valid_r <= bus.SEND_INTERRUPT;
            if (bus.SEND_INTERRUPT) begin
                s1_pkt_r <= s1_pkt_s;
            end
        end
    end

    assign apply_s = s1_valid_r & ~bus.RECENTRE;

    // Stage 2: status, button edges and overflow count; status_r doubles as previous buttons.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            status_r      <= 4'd0;
            btn_press_r   <= 3'b000;
            btn_release_r <= 3'b000;
            pos_valid_r   <= 1'b0;
            ovf_count_r   <= 8'd0;
        end else begin
            pos_valid_r   <= apply_s;
            btn_press_r   <= 3'b000;
            btn_release_r <= 3'b000;
            if (apply_s) begin
                status_r      <= s1_pkt_r.status;
                btn_press_r   <= s1_pkt_r.status[BTN_M:BTN_L] & ~status_r[BTN_M:BTN_L];
                btn_release_r <= ~s1_pkt_r.status[BTN_M:BTN_L] & status_r[BTN_M:BTN_L];
                if (s1_pkt_r.ovf && (ovf_count_r != OVF_COUNT_MAX)) begin
                    ovf_count_r <= ovf_count_r + 8'd1;
                end
            end
        end
    end

    mouse_axis_accumulator #(
        .LIMIT(LIMIT_X), .POS_WIDTH(POS_WIDTH), .SCALE_SHIFT(SCALE_SHIFT), .WRAP_MODE(WRAP_MODE)
    ) u_axis_x (
        .clk(CLK), .rst(RESET), .recentre(bus.RECENTRE), .apply(s1_valid_r),
        .delta(s1_pkt_r.dx), .pos(x_pos_s)
    );

    mouse_axis_accumulator #(
        .LIMIT(LIMIT_Y), .POS_WIDTH(POS_WIDTH), .SCALE_SHIFT(SCALE_SHIFT), .WRAP_MODE(WRAP_MODE)
    ) u_axis_y (
        .clk(CLK), .rst(RESET), .recentre(bus.RECENTRE), .apply(s1_valid_r),
        .delta(s1_pkt_r.dy), .pos(y_pos_s)
    );

    mouse_axis_accumulator #(
        .LIMIT(LIMIT_Z), .POS_WIDTH(POS_WIDTH), .SCALE_SHIFT(SCALE_SHIFT), .WRAP_MODE(WRAP_MODE)
    ) u_axis_z (
        .clk(CLK), .rst(RESET), .recentre(bus.RECENTRE), .apply(s1_valid_r),
        .delta(s1_pkt_r.dz), .pos(z_pos_s)
    );

    assign bus.MOUSE_X      = x_pos_s;
    assign bus.MOUSE_Y      = y_pos_s;
    assign bus.MOUSE_Z      = z_pos_s;
    assign bus.MOUSE_STATUS = status_r;
    assign bus.BTN_PRESS    = btn_press_r;
    assign bus.BTN_RELEASE  = btn_release_r;
    assign bus.POS_VALID    = pos_valid_r;
    assign bus.OVF_COUNT    = ovf_count_r;

endmodule
